vending_machine_param: RTL and testbench

Parametrised successor to the fixed four-item vending controller. Supports a configurable item count and price list and a wide credit accumulator in $10 units. Adds cancel/refund and refunds any coins inserted while the machine is busy. Change is returned as a serial stream of $10 coin pulses. Sits between the coin acceptor / keypad front end and the dispenser and coin-hopper drivers.

---
 rtl/vm_pkg.sv | 19 +
 rtl/vending_machine_param_if.sv | 35 +++
 rtl/vending_machine_param_checker.sv | 18 +
 rtl/vm_stock_bank.sv | 42 ++++
 rtl/vending_machine_param.sv | 165 ++++++++++++++++
 tb/tb_vending_machine_param.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/vm_pkg.sv
// Shared types and coin helpers for the parametrised vending controller.
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vm_state_e;

    localparam logic [2:0] COIN10_UNITS = 3'd1;
    localparam logic [2:0] COIN50_UNITS = 3'd5;

    // Credit value of the coins seen in one cycle, in $10 units.
    function automatic logic [2:0] coin_units(input logic d10, input logic d50);
        coin_units = (d10 ? COIN10_UNITS : 3'd0) + (d50 ? COIN50_UNITS : 3'd0);
    endfunction

endpackage

// File: rtl/vending_machine_param_if.sv
// Front-end / dispenser signal bundle. sold_out exists only when STOCK_COUNT_EN is defined.
interface vending_machine_param_if #(
    parameter int ITEM_W   = 2,
    parameter int CREDIT_W = 8
);
    logic [ITEM_W-1:0]   item;
    logic                sel;
    logic                dollar_10;
    logic                dollar_50;
    logic                cancel;
    logic [CREDIT_W-1:0] price;
    logic                release_valid;
    logic [ITEM_W-1:0]   release_item;
    logic                change_return;
    logic                busy;
`ifdef STOCK_COUNT_EN
    logic                sold_out;
`endif

    modport master (
        output item, sel, dollar_10, dollar_50, cancel,
`ifdef STOCK_COUNT_EN
        input  sold_out,
`endif
        input  price, release_valid, release_item, change_return, busy
    );

    modport slave (
        input  item, sel, dollar_10, dollar_50, cancel,
`ifdef STOCK_COUNT_EN
        output sold_out,
`endif
        output price, release_valid, release_item, change_return, busy
    );
endinterface

// File: rtl/vending_machine_param_checker.sv
// Simulation-only checks: configuration sanity and lost refund coins.
module vending_machine_param_checker #(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 15
) (
    input logic clk,
    input logic reset,
    input logic change_ovf
);
    localparam bit CFG_OK = (NUM_ITEMS >= 2) && (NUM_ITEMS <= 16) &&
                            (((1 << CREDIT_W) - 1) >= 21) &&
                            (STOCK_INIT >= 0) && (STOCK_INIT < (1 << STOCK_W));

    cfg_ok_a: assert property (@(posedge clk) disable iff (!reset) CFG_OK);
    no_refund_loss_a: assert property (@(posedge clk) disable iff (!reset) !change_ovf);
endmodule

// File: rtl/vm_stock_bank.sv
// Per-item stock counters with a decrement port and an empty query (STOCK_COUNT_EN builds).
module vm_stock_bank #(
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = 2,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [ITEM_W-1:0] dec_item,
    input  logic [ITEM_W-1:0] query_item,
    output logic              empty
);
    localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0] ONE_V  = {{(STOCK_W-1){1'b0}}, 1'b1};

    logic [STOCK_W-1:0] stock_r [NUM_ITEMS];

    // Stock counters: reload on reset, count down on each dispense, never wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock_r[i] <= INIT_V;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (dec_valid && (int'(dec_item) == i) && (stock_r[i] != '0))
                    stock_r[i] <= stock_r[i] - ONE_V;
                else
                    stock_r[i] <= stock_r[i];
            end
        end
    end

    // Out-of-range selections report empty so they can never start a sale.
    always_comb begin
        empty = 1'b1;
        if (int'(query_item) < NUM_ITEMS)
            empty = (stock_r[query_item] == '0);
        else
            empty = 1'b1;
    end
endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: collect, vend, serial $10 change. Optional stock via STOCK_COUNT_EN.
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int                     NUM_ITEMS  = 4,
    parameter int                     ITEM_W     = $clog2(NUM_ITEMS),
    parameter int                     CREDIT_W   = 8,
    parameter logic [4*NUM_ITEMS-1:0] PRICE_LIST = {4'd5, 4'd4, 4'd3, 4'd2},
    parameter int                     STOCK_W    = 4,
    parameter int                     STOCK_INIT = 15
) (
    input logic              clk,
    input logic              reset,
    vending_machine_param_if.slave bus
);
    localparam logic [CREDIT_W-1:0] ONE_C = {{(CREDIT_W-1){1'b0}}, 1'b1};

    vm_state_e           state_r, nstate_s;
    logic [CREDIT_W-1:0] due_r, credit_r, change_cnt_r;
    logic [CREDIT_W-1:0] ndue_s, ncredit_s, ncnt_s;
    logic [ITEM_W-1:0]   sel_item_r, nitem_s;
    logic [CREDIT_W-1:0] price_r, price_next_s;
    logic                release_valid_r, change_return_r, busy_r;
    logic [ITEM_W-1:0]   release_item_r;
    logic [2:0]          coin_s;
    logic [CREDIT_W:0]   credit_sum_s, refund_sum_s;
    logic [CREDIT_W-1:0] refund_base_s, refund_sat_s;
    logic                item_ok_s, empty_s, change_ovf_s;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
        price_of = {{(CREDIT_W-4){1'b0}}, PRICE_LIST[int'(idx)*4 +: 4]};
    endfunction

`ifdef STOCK_COUNT_EN
    logic sold_out_r, nsold_s;

    vm_stock_bank #(
        .NUM_ITEMS (NUM_ITEMS),
        .ITEM_W    (ITEM_W),
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_stock (
        .clk       (clk),
        .reset     (reset),
        .dec_valid (release_valid_r),
        .dec_item  (release_item_r),
        .query_item(bus.item),
        .empty     (empty_s)
    );
    assign bus.sold_out = sold_out_r;
`else
    assign empty_s = 1'b0;
`endif

    vending_machine_param_checker #(
        .NUM_ITEMS (NUM_ITEMS),
        .CREDIT_W  (CREDIT_W),
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .change_ovf(change_ovf_s)
    );

    // Coin arithmetic: credit in COLLECT, saturating refund/change counter in VEND and CHANGE.
    always_comb begin
        coin_s        = coin_units(bus.dollar_10, bus.dollar_50);
        item_ok_s     = (int'(bus.item) < NUM_ITEMS);
        credit_sum_s  = {1'b0, credit_r} + {{(CREDIT_W-2){1'b0}}, coin_s};
        refund_base_s = (state_r == CHANGE) ? (change_cnt_r - ONE_C) : change_cnt_r;
        refund_sum_s  = {1'b0, refund_base_s} + {{(CREDIT_W-2){1'b0}}, coin_s};
        refund_sat_s  = refund_sum_s[CREDIT_W] ? {CREDIT_W{1'b1}} : refund_sum_s[CREDIT_W-1:0];
        change_ovf_s  = refund_sum_s[CREDIT_W] && ((state_r == VEND) || (state_r == CHANGE));
    end

    // Next-state and next-counter decisions.
    always_comb begin
        nstate_s  = state_r;
        ndue_s    = due_r;
        ncredit_s = credit_r;
        ncnt_s    = change_cnt_r;
        nitem_s   = sel_item_r;
`ifdef STOCK_COUNT_EN
        nsold_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (bus.sel && item_ok_s && !empty_s) begin
                    nstate_s  = COLLECT;
                    nitem_s   = bus.item;
                    ndue_s    = price_of(bus.item);
                    ncredit_s = '0;
                end
`ifdef STOCK_COUNT_EN
                else if (bus.sel && item_ok_s) begin
                    nsold_s = 1'b1;
                end
`endif
                else begin
                    nstate_s = IDLE;
                end
            end
            COLLECT: begin
                if (bus.cancel) begin
                    ncnt_s   = credit_sum_s[CREDIT_W-1:0];
                    nstate_s = (credit_sum_s != '0) ? CHANGE : IDLE;
                end else if (credit_sum_s >= {1'b0, due_r}) begin
                    nstate_s  = VEND;
                    ncredit_s = credit_sum_s[CREDIT_W-1:0];
                    ncnt_s    = credit_sum_s[CREDIT_W-1:0] - due_r;
                end else begin
                    ncredit_s = credit_sum_s[CREDIT_W-1:0];
                end
            end
            VEND, CHANGE: begin
                ncnt_s   = refund_sat_s;
                nstate_s = (refund_sat_s != '0) ? CHANGE : IDLE;
            end
            default: begin
                nstate_s = IDLE;
            end
        endcase
        price_next_s = ((nstate_s == COLLECT) && (ndue_s > ncredit_s)) ? (ndue_s - ncredit_s) : '0;
    end

    // FSM state, counters and registered outputs, all derived from the next-state view.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            due_r           <= '0;
            credit_r        <= '0;
            change_cnt_r    <= '0;
            sel_item_r      <= '0;
            price_r         <= '0;
            release_valid_r <= 1'b0;
            release_item_r  <= '0;
            change_return_r <= 1'b0;
            busy_r          <= 1'b0;
`ifdef STOCK_COUNT_EN
            sold_out_r      <= 1'b0;
`endif
        end else begin
            state_r         <= nstate_s;
            due_r           <= ndue_s;
            credit_r        <= ncredit_s;
            change_cnt_r    <= ncnt_s;
            sel_item_r      <= nitem_s;
            price_r         <= price_next_s;
            release_valid_r <= (nstate_s == VEND);
            release_item_r  <= (nstate_s == VEND) ? nitem_s : release_item_r;
            change_return_r <= (nstate_s == CHANGE);
            busy_r          <= (nstate_s != IDLE);
`ifdef STOCK_COUNT_EN
            sold_out_r      <= nsold_s;
`endif
        end
    end

    assign bus.price         = price_r;
    assign bus.release_valid = release_valid_r;
    assign bus.release_item  = release_item_r;
    assign bus.change_return = change_return_r;
    assign bus.busy          = busy_r;
endmodule

// File: tb/tb_vending_machine_param.sv
// Self-checking bench for vending_machine_param: vector table, random transactions, corner sequences.
module tb_vending_machine_param;

`ifdef STOCK_COUNT_EN
    localparam int STOCK_INIT_TB = 1;
`else
    localparam int STOCK_INIT_TB = 15;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vending_machine_param_if #(.ITEM_W(2), .CREDIT_W(8)) vif ();

    vending_machine_param #(
        .NUM_ITEMS (4),
        .ITEM_W    (2),
        .CREDIT_W  (8),
        .PRICE_LIST(16'h5432),
        .STOCK_W   (4),
        .STOCK_INIT(STOCK_INIT_TB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (vif)
    );

    int vectors     = 0;
    int miscompares = 0;
    int price_tab [4] = '{2, 3, 4, 5};
    int bench_stock [4];

    typedef struct {
        int          item;
        logic [15:0] coins;      // slot k at [2k+1:2k], bit0 = $10, bit1 = $50
        int          ncoins;
        int          cancel_at;  // slot index carrying cancel, -1 for none
        int          exp_rel;
        int          exp_chg;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int units(input logic [1:0] code);
        return (code[0] ? 1 : 0) + (code[1] ? 5 : 0);
    endfunction

    task automatic idle_inputs();
        vif.sel = 1'b0; vif.item = 2'd0; vif.dollar_10 = 1'b0;
        vif.dollar_50 = 1'b0; vif.cancel = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", vif.busy, 0);
        check("rst_price", vif.price, 0);
        check("rst_rel", vif.release_valid, 0);
        check("rst_item", vif.release_item, 0);
        check("rst_chg", vif.change_return, 0);
`ifdef STOCK_COUNT_EN
        check("rst_sold", vif.sold_out, 0);
`endif
        for (int i = 0; i < 4; i++) bench_stock[i] = STOCK_INIT_TB;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One purchase attempt; the expected timeline is computed from the pricing rules.
    task automatic run_txn(input int item, input logic [15:0] coins, input int ncoins,
                           input int cancel_at, input logic [1:0] idle_coin,
                           output int rel_cnt, output int chg_cnt);
        int p, cum, end_k, e, n, last;
        bit canceled;
        int pre [10];
        logic [1:0] code;
        rel_cnt = 0;
        chg_cnt = 0;
`ifdef STOCK_COUNT_EN
        if (bench_stock[item] == 0) begin
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                check("so_busy", vif.busy, 0);
                check("so_pulse", vif.sold_out, (c == 1));
                check("so_rel", vif.release_valid, 0);
                vif.sel = (c == 0); vif.item = 2'(item);
            end
            vif.sel = 1'b0;
            return;
        end
`endif
        p = price_tab[item]; cum = 0; end_k = ncoins - 1; canceled = 1'b0; pre[0] = 0;
        for (int k = 0; k < ncoins; k++) begin
            cum += units(coins[2*k +: 2]);
            pre[k+1] = cum;
            if (k == cancel_at) begin canceled = 1'b1; end_k = k; break; end
            if (cum >= p) begin end_k = k; break; end
        end
        e = end_k + 1;
        n = canceled ? cum : cum - p;
        last = canceled ? e + n : e + 1 + n;
        for (int c = 0; c <= last + 2; c++) begin
            @(posedge clk); #1;
            check("busy", vif.busy, (c >= 1 && c <= last));
            check("rel", vif.release_valid, (!canceled && c == e + 1));
            check("chg", vif.change_return,
                  canceled ? (c > e && c <= e + n) : (c > e + 1 && c <= e + 1 + n));
            check("price", vif.price, (c >= 1 && c <= e) ? p - pre[c-1] : 0);
            if (!canceled && c == e + 1) check("rel_item", vif.release_item, item);
`ifdef STOCK_COUNT_EN
            check("sold", vif.sold_out, 0);
`endif
            rel_cnt += int'(vif.release_valid);
            chg_cnt += int'(vif.change_return);
            code = (c == 0) ? idle_coin : ((c >= 1 && c <= e) ? coins[2*(c-1) +: 2] : 2'b00);
            vif.sel = (c == 0); vif.item = 2'(item);
            vif.dollar_10 = code[0]; vif.dollar_50 = code[1];
            vif.cancel = canceled && (c == e);
        end
        if (!canceled) bench_stock[item]--;
    endtask

    // Item 1 paid with $60, an extra $10 at refund_c during VEND/CHANGE: 4 change pulses.
    task automatic refund_seq(input int refund_c, input string nm);
        int pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 2) check({nm, "_rel"}, vif.release_valid, 1);
            if (c == 6) check({nm, "_busy6"}, vif.busy, 1);
            if (c == 7) check({nm, "_busy7"}, vif.busy, 0);
            pulses += int'(vif.change_return);
            vif.sel = (c == 0); vif.item = 2'd1;
            vif.dollar_10 = (c == 1) || (c == refund_c);
            vif.dollar_50 = (c == 1); vif.cancel = 1'b0;
        end
        check({nm, "_pulses"}, pulses, 4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rel, chg, item, p, cum, nc, cancel_at;
        logic [15:0] coins;
        logic [1:0] code, idle;

        tbl[0] = '{0, 16'h0005, 2, -1, 1, 0};
        tbl[1] = '{0, 16'h0002, 1, -1, 1, 3};
        tbl[2] = '{3, 16'h0001, 2,  1, 0, 1};
        tbl[3] = '{1, 16'h0003, 1, -1, 1, 3};
        tbl[4] = '{2, 16'h0002, 1, -1, 1, 1};
        tbl[5] = '{3, 16'h0002, 1, -1, 1, 0};
        tbl[6] = '{1, 16'h0000, 1,  0, 0, 0};
        tbl[7] = '{2, 16'h0002, 1,  0, 0, 5};
        tbl[8] = '{3, 16'h0155, 5, -1, 1, 0};
        tbl[9] = '{3, 16'h0255, 5, -1, 1, 4};

        do_reset();
        for (int i = 0; i < 10; i++) begin
`ifdef STOCK_COUNT_EN
            do_reset();
`endif
            run_txn(tbl[i].item, tbl[i].coins, tbl[i].ncoins, tbl[i].cancel_at, 2'b00, rel, chg);
            check($sformatf("tbl%0d_rel", i), rel, tbl[i].exp_rel);
            check($sformatf("tbl%0d_chg", i), chg, tbl[i].exp_chg);
        end

        do_reset();
        refund_seq(3, "refund_change");
        do_reset();
        refund_seq(2, "refund_vend");

        // Reset while two change units are still pending.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 2) check("rstmid_rel", vif.release_valid, 1);
            if (c >= 3) check("rstmid_chg", vif.change_return, 1);
            vif.sel = (c == 0); vif.item = 2'd0; vif.dollar_50 = (c == 1);
        end
        idle_inputs();
        reset = 1'b0;
        #1;
        check("rstmid_busy0", vif.busy, 0);
        check("rstmid_chg0", vif.change_return, 0);
        check("rstmid_rel0", vif.release_valid, 0);
        check("rstmid_price0", vif.price, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) bench_stock[i] = STOCK_INIT_TB;
        chg = 0; rel = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chg += int'(vif.change_return);
            rel += int'(vif.release_valid) + int'(vif.busy);
        end
        check("rstmid_after_chg", chg, 0);
        check("rstmid_after_busy", rel, 0);

`ifdef STOCK_COUNT_EN
        do_reset();
        run_txn(2, 16'h0002, 1, -1, 2'b00, rel, chg);
        check("stock_first_rel", rel, 1);
        run_txn(2, 16'h0002, 1, -1, 2'b00, rel, chg);
        check("stock_second_rel", rel, 0);
`endif

        do_reset();
        for (int t = 0; t < 40; t++) begin
            item = $urandom_range(0, 3);
            p = price_tab[item]; cum = 0; coins = '0; nc = 0; cancel_at = -1;
            for (int k = 0; k < 8; k++) begin
                code = (k == 7) ? 2'b10 : 2'($urandom_range(0, 3));
                coins[2*k +: 2] = code;
                nc = k + 1;
                if ($urandom_range(0, 7) == 0) begin cancel_at = k; break; end
                cum += units(code);
                if (cum >= p) break;
            end
            idle = 2'($urandom_range(0, 3));
            run_txn(item, coins, nc, cancel_at, idle, rel, chg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
